// File: rtl/hilo_mult_unit.sv
// Multi-cycle shift-add multiplier with architectural HI/LO registers for the EX stage.
// Raises stall_E while a multiply is in flight and a mult/mf/mt instruction reaches EX.
module hilo_mult_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult_we_E,
    input  logic             mult_signed_E,
    input  logic [WIDTH-1:0] a_E,
    input  logic [WIDTH-1:0] b_E,
    input  logic             mf_rd_E,
    input  logic             mf_hilo_sel_E,
    input  logic             mt_we_E,
    input  logic             abort,
    output logic [WIDTH-1:0] hilo_rd,
    output logic             busy,
    output logic             done,
    output logic             stall_E
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [DW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [DW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;

    logic             w_start;
    logic             w_mt_wr;
    logic             w_last;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [DW-1:0]    w_result;

    // Magnitudes are only taken for signed multiplies; the most negative value maps to 2^(W-1).
    assign w_a_mag  = (mult_signed_E & a_E[WIDTH-1]) ? (WIDTH'(0) - a_E) : a_E;
    assign w_b_mag  = (mult_signed_E & b_E[WIDTH-1]) ? (WIDTH'(0) - b_E) : b_E;
    assign w_start  = (r_state == S_IDLE) & mult_we_E & ~abort;
    assign w_mt_wr  = (r_state == S_IDLE) & mt_we_E & ~mult_we_E & ~abort;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_result = r_neg ? (DW'(0) - r_acc) : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
            S_BUSY: begin
                if (abort)       w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_FIN;
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_FIN);
        stall_E = (r_state != S_IDLE) & (mult_we_E | mf_rd_E | mt_we_E) & ~abort;
        hilo_rd = mf_hilo_sel_E ? r_hi : r_lo;
    end

    // Datapath: operand capture, one shift-add step per BUSY cycle, HI/LO commit in FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mcand  <= {WIDTH'(0), w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= mult_signed_E & (a_E[WIDTH-1] ^ b_E[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end else if (w_mt_wr) begin
                        if (mf_hilo_sel_E) r_hi <= a_E;
                        else               r_lo <= a_E;
                    end
                end
                S_BUSY: begin
                    r_acc    <= r_acc + (r_mplier[0] ? r_mcand : DW'(0));
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                end
                S_FIN: begin
                    if (!abort) begin
                        r_hi <= w_result[DW-1:WIDTH];
                        r_lo <= w_result[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
